imem_port_arbiter: RTL

- Shares the single combinational read port of the instruction memory between two requesters: the instruction fetch stage and a load path that reads constants or literal pools from code space.
- Uses a req/gnt/rvalid handshake on each requester side and drives one address into the memory.
- Read data returns, registered, exactly one cycle after grant.
- Sits between the fetch/LSU stages and the instruction memory in the core.

---
 rtl/imem_port_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// Arbiter sharing the instruction memory read port between fetch and the LSU.
// Grants are combinational and responses are registered one cycle after the grant.
module imem_port_arbiter #(
    parameter int IMEM_W     = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_req_i,
    input  logic [IMEM_W-1:0] fetch_addr_i,
    input  logic              fetch_flush_i,
    output logic              fetch_gnt_o,
    output logic              fetch_rvalid_o,
    output logic [31:0]       fetch_rdata_o,
    input  logic              lsu_req_i,
    input  logic [IMEM_W-1:0] lsu_addr_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [31:0]       lsu_rdata_o,
    output logic              lsu_err_o,
    output logic [IMEM_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       fetch_live;
    logic       fetch_starved;
    logic       fetch_gnt;
    logic       lsu_gnt;
    logic       lsu_misaligned;
    logic       fetch_rvalid_q;
    logic       lsu_rvalid_q;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        fetch_live     = 1'b0;
        fetch_starved  = 1'b0;
        fetch_gnt      = 1'b0;
        lsu_gnt        = 1'b0;
        lsu_misaligned = 1'b0;
        if (!rst_i) begin
            fetch_live     = fetch_req_i && !fetch_flush_i;
            fetch_starved  = (starve_cnt == STARVE_LIM);
            // LSU wins unless fetch has been denied STARVE_MAX cycles in a row.
            fetch_gnt      = fetch_live && (!lsu_req_i || fetch_starved);
            lsu_gnt        = lsu_req_i && !(fetch_live && fetch_starved);
            lsu_misaligned = (lsu_addr_i[1:0] != 2'b00);
        end
    end

    assign fetch_gnt_o = fetch_gnt;
    assign lsu_gnt_o   = lsu_gnt;
    assign mem_addr_o  = lsu_gnt ? lsu_addr_i : fetch_addr_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= 4'd0;
        end else if (fetch_live && !fetch_gnt) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_rvalid_q <= 1'b0;
            fetch_rdata_o  <= 32'd0;
            lsu_rvalid_q   <= 1'b0;
            lsu_rdata_o    <= 32'd0;
            lsu_err_o      <= 1'b0;
        end else begin
            fetch_rvalid_q <= fetch_gnt;
            lsu_rvalid_q   <= lsu_gnt;
            lsu_err_o      <= lsu_gnt && lsu_misaligned;
            if (fetch_gnt) begin
                fetch_rdata_o <= mem_rdata_i;
            end
            if (lsu_gnt) begin
                lsu_rdata_o <= lsu_misaligned ? 32'd0 : mem_rdata_i;
            end
        end
    end

    // A response due in a reset cycle is dropped rather than handed to a stage being reset.
    assign fetch_rvalid_o = fetch_rvalid_q && !rst_i;
    assign lsu_rvalid_o   = lsu_rvalid_q && !rst_i;

    gnt_exclusive_a: assert property (@(posedge clk_i) !(fetch_gnt && lsu_gnt));

endmodule
